// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle HI/LO multiply/divide unit for the EX stage
// A launch latches operands; the result is computed from the latched copy and committed on the last busy cycle.
module mdu_unit #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOP,
    input  logic        start,
    input  logic        req,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOUT
);

    localparam logic       S_IDLE  = 1'b0;
    localparam logic       S_RUN   = 1'b1;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [4:0] L_MULT   = 5'(MULT_CYC);
    localparam logic [4:0] L_DIV    = 5'(DIV_CYC);

    logic        r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_op;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_idle;
    logic        w_arith_op;
    logic        w_launch;
    logic        w_commit;
    logic        w_is_mult;
    logic        w_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_div_zero;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_idle     = (r_state == S_IDLE);
    assign w_arith_op = (MDOP >= OP_MULT) && (MDOP <= OP_DIVU);
    assign w_launch   = w_idle && start && !req && w_arith_op;
    assign w_commit   = (r_state == S_RUN) && (r_cnt == 5'd1);
    assign w_is_mult  = (r_op == OP_MULT) || (r_op == OP_MULTU);
    assign w_signed   = (r_op == OP_MULT) || (r_op == OP_DIV);

    // Sign-extending to 64 bits lets one unsigned multiply serve both mult and multu.
    assign w_ext_a = {{32{w_signed & r_a[31]}}, r_a};
    assign w_ext_b = {{32{w_signed & r_b[31]}}, r_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide works on magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
    assign w_neg_a    = w_signed & r_a[31];
    assign w_neg_b    = w_signed & r_b[31];
    assign w_abs_a    = w_neg_a ? (32'd0 - r_a) : r_a;
    assign w_abs_b    = w_neg_b ? (32'd0 - r_b) : r_b;
    assign w_div_zero = (r_b == 32'd0);
    assign w_uq       = w_div_zero ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_ur       = w_div_zero ? 32'd0 : (w_abs_a % w_abs_b);
    assign w_quot     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_rem      = w_neg_a ? (32'd0 - w_ur) : w_ur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (w_idle) begin
            if (w_launch) begin
                r_state <= S_RUN;
                r_a     <= A;
                r_b     <= B;
                r_op    <= MDOP;
                r_cnt   <= ((MDOP == OP_MULT) || (MDOP == OP_MULTU)) ? L_MULT : L_DIV;
            end else if (!req && (MDOP == OP_MTHI)) begin
                r_hi <= A;
            end else if (!req && (MDOP == OP_MTLO)) begin
                r_lo <= A;
            end
        end else begin
            r_cnt <= r_cnt - 5'd1;
            if (w_commit) begin
                r_state <= S_IDLE;
                if (w_is_mult) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (!w_div_zero) begin
                    r_hi <= w_rem;
                    r_lo <= w_quot;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

    always_comb begin
        MDOUT = 32'd0;
        if (MDOP == OP_MFHI) begin
            MDOUT = r_hi;
        end else if (MDOP == OP_MFLO) begin
            MDOUT = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
// Inputs change on the falling edge; outputs are sampled there too, half a period from the active edge.
module tb_mdu_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDOP;
    logic        start;
    logic        req;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDOUT;

    int n_checks;
    int n_fail;

    mdu_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .MDOP  (MDOP),
        .start (start),
        .req   (req),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO),
        .MDOUT (MDOUT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Launch at the current falling edge, then count busy cycles until idle (bounded).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int ncyc);
        A = a; B = b; MDOP = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDOP = 4'd0;
        ncyc = 0;
        while (busy && ncyc < 60) begin
            ncyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_move(input logic [3:0] op, input logic [31:0] a, input logic r);
        A = a; MDOP = op; req = r;
        @(negedge clk);
        MDOP = 4'd0; req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; A = '0; B = '0; MDOP = 4'd7; start = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || MDOUT !== 32'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b HI=%h LO=%h MDOUT=%h, want 0/0/0/0", busy, HI, LO, MDOUT);
        end
        rst_n = 1'b1; MDOP = 4'd0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        int n;
        do_op(4'd1, 32'hFFFFFFFE, 32'd3, n);
        n_checks++;
        if (n !== 5) begin n_fail++; $display("FAIL mult_busy: got %0d cycles, want 5", n); end
        n_checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL mult_result: HI=%h LO=%h, want ffffffff/fffffffa", HI, LO);
        end
        do_op(4'd2, 32'hFFFFFFFE, 32'd3, n);
        n_checks++;
        if (n !== 5 || HI !== 32'h00000002 || LO !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL multu: cyc=%0d HI=%h LO=%h, want 5 00000002/fffffffa", n, HI, LO);
        end
    endtask

    task automatic test_div;
        int n;
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, n);
        n_checks++;
        if (n !== 10) begin n_fail++; $display("FAIL div_busy: got %0d cycles, want 10", n); end
        n_checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
            n_fail++; $display("FAIL div_result: HI=%h LO=%h, want ffffffff/fffffffd", HI, LO);
        end
        do_op(4'd4, 32'd7, 32'd2, n);
        n_checks++;
        if (n !== 10 || HI !== 32'd1 || LO !== 32'd3) begin
            n_fail++; $display("FAIL divu: cyc=%0d HI=%h LO=%h, want 10 1/3", n, HI, LO);
        end
    endtask

    task automatic test_div_edges;
        int n;
        do_move(4'd5, 32'h11, 1'b0);
        do_move(4'd6, 32'h22, 1'b0);
        do_op(4'd3, 32'd1234, 32'd0, n);
        n_checks++;
        if (n !== 10 || HI !== 32'h11 || LO !== 32'h22) begin
            n_fail++; $display("FAIL div_by_zero: cyc=%0d HI=%h LO=%h, want 10 11/22", n, HI, LO);
        end
        do_op(4'd4, 32'd99, 32'd0, n);
        n_checks++;
        if (n !== 10 || HI !== 32'h11 || LO !== 32'h22) begin
            n_fail++; $display("FAIL divu_by_zero: cyc=%0d HI=%h LO=%h, want 10 11/22", n, HI, LO);
        end
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'h80000000) begin
            n_fail++; $display("FAIL div_overflow: HI=%h LO=%h, want 00000000/80000000", HI, LO);
        end
    endtask

    task automatic test_busy_interlock;
        int n;
        A = 32'hFFFFFFFE; B = 32'd3; MDOP = 4'd1; start = 1'b1;
        @(negedge clk);
        A = 32'd100; B = 32'd7; MDOP = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDOP = 4'd5; A = 32'h55;
        @(negedge clk);
        MDOP = 4'd0;
        n = 0;
        while (busy && n < 60) begin n++; @(negedge clk); end
        n_checks++;
        if (n !== 3) begin n_fail++; $display("FAIL interlock_busy: %0d remaining cycles, want 3", n); end
        n_checks++;
        if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFA) begin
            n_fail++; $display("FAIL interlock_result: HI=%h LO=%h, want ffffffff/fffffffa", HI, LO);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        do_op(4'd2, 32'h00010000, 32'h00010000, n);
        n_checks++;
        if (n !== 5 || HI !== 32'd1 || LO !== 32'd0) begin
            n_fail++; $display("FAIL b2b_first: cyc=%0d HI=%h LO=%h, want 5 1/0", n, HI, LO);
        end
        do_op(4'd4, 32'd7, 32'd2, n);
        n_checks++;
        if (n !== 10 || HI !== 32'd1 || LO !== 32'd3) begin
            n_fail++; $display("FAIL b2b_second: cyc=%0d HI=%h LO=%h, want 10 1/3", n, HI, LO);
        end
    endtask

    task automatic test_req_in_run;
        int n;
        A = 32'd6; B = 32'd7; MDOP = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDOP = 4'd0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        n = 0;
        while (busy && n < 60) begin n++; @(negedge clk); end
        n_checks++;
        if (HI !== 32'd0 || LO !== 32'd42) begin
            n_fail++; $display("FAIL req_in_run: HI=%h LO=%h, want 0/2a", HI, LO);
        end
    endtask

    task automatic test_flush_move;
        logic [31:0] lo_before;
        lo_before = LO;
        A = 32'hABCD; MDOP = 4'd6; req = 1'b1; start = 1'b1;
        @(negedge clk);
        n_checks++;
        if (LO !== lo_before || busy !== 1'b0) begin
            n_fail++; $display("FAIL mtlo_flushed: LO=%h busy=%b, want %h 0", LO, busy, lo_before);
        end
        start = 1'b0; req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (LO !== 32'hABCD) begin n_fail++; $display("FAIL mtlo: LO=%h, want 0000abcd", LO); end
        MDOP = 4'd8; #1;
        n_checks++;
        if (MDOUT !== 32'hABCD) begin n_fail++; $display("FAIL mflo: MDOUT=%h, want 0000abcd", MDOUT); end
        MDOP = 4'd7; #1;
        n_checks++;
        if (MDOUT !== 32'd0) begin n_fail++; $display("FAIL mfhi: MDOUT=%h, want 0", MDOUT); end
        MDOP = 4'd0; #1;
        n_checks++;
        if (MDOUT !== 32'd0) begin n_fail++; $display("FAIL mdout_none: MDOUT=%h, want 0", MDOUT); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        int n;
        do_move(4'd5, 32'h1234, 1'b0);
        A = 32'd100; B = 32'd3; MDOP = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDOP = 4'd0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++; $display("FAIL async_reset: busy=%b HI=%h LO=%h, want 0/0/0", busy, HI, LO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(4'd1, 32'd4, 32'd5, n);
        n_checks++;
        if (n !== 5 || HI !== 32'd0 || LO !== 32'd20) begin
            n_fail++; $display("FAIL post_reset_mult: cyc=%0d HI=%h LO=%h, want 5 0/14", n, HI, LO);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mult();
        test_div();
        test_div_edges();
        test_busy_interlock();
        test_back_to_back();
        test_req_in_run();
        test_flush_move();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Multi-cycle multiply/divide unit for the pipelined MIPS core. It executes the HI/LO-class instructions the single-cycle ALU does not: mult, multu, div, divu, mthi, mtlo, mfhi and mflo. It sits in the EX stage next to the ALU and takes the same forwarded operands. Its `busy`/`start` handshake drives the hazard unit's stall of any HI/LO-dependent instruction.

## Interface
- `MULT_CYC`, default 5: cycles `busy` stays high for mult/multu.
- `DIV_CYC`, default 10: cycles `busy` stays high for div/divu.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `A`  in  32: operand rs (dividend / multiplicand; source for mthi/mtlo).
- `B`  in  32: operand rt (divisor / multiplier).
- `MDOP`  in  4: opcode. 0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo, 7=mfhi, 8=mflo; other values behave as none.
- `start`  in  1: one-cycle pulse that launches opcodes 1–4.
- `req`  in  1: exception/interrupt flush in EX; suppresses any launch or HI/LO write in the same cycle.
- `busy`  out  1: an operation is in flight.
- `HI`  out  32: architectural HI register.
- `LO`  out  32: architectural LO register.
- `MDOUT`  out  32: read data; HI when MDOP=7, LO when MDOP=8, 0 otherwise (combinational).

## Operation
- State machine IDLE → RUN → IDLE, with a down-counter `cnt` (5 bits).
- IDLE:
  - `start`=1, MDOP∈{1..4}, `req`=0: latch operands and opcode, load `cnt` with MULT_CYC or DIV_CYC, go to RUN.
  - MDOP=5/6 with `req`=0: HI/LO ← A at the edge.
- RUN: `cnt` decrements each cycle. When `cnt` reaches 1, commit results to HI/LO at that edge and return to IDLE.
- Arithmetic:
  - mult: signed 32×32 → 64-bit product.
  - multu: unsigned 32×32 → 64-bit product.
  - In both, HI = product[63:32] and LO = product[31:0].
  - div/divu: LO = quotient, HI = remainder.
  - div is signed: quotient truncates toward zero; the remainder takes the dividend's sign.
- Boundary cases:
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (B=0, div or divu): full DIV_CYC latency; HI/LO left unchanged.
  - `start` or MDOP=5/6 while `busy`: ignored. The pipeline must stall these; the unit does not queue them.
  - `req` during RUN: no effect. The in-flight operation belongs to an older, committed instruction and completes.
  - `start` with MDOP∉{1..4}: ignored.
- Reset (`rst_n`=0, any time including mid-operation): HI=0, LO=0, `busy`=0, `cnt`=0, state IDLE, latched operands cleared. The in-flight result is discarded.

## Timing
- Cycle 0: `start` sampled high. Cycles 1..N: `busy`=1, where N = MULT_CYC or DIV_CYC.
- The new HI/LO values are visible from cycle N+1, the same cycle `busy` returns to 0.
- A new `start` is accepted in cycle N+1 (back-to-back operations allowed).
- mthi/mtlo: written at the edge ending cycle 0; visible cycle 1. `busy` is never raised.
- mfhi/mflo: `MDOUT` reflects current HI/LO with zero latency.
- The hazard unit stalls mfhi/mflo/mthi/mtlo/mult/div in EX while `busy`=1 or `start`=1.
- Outputs after reset: `busy`=0, HI=0, LO=0, `MDOUT`=0.

## Test plan
- Signed multiply: mult A=0xFFFFFFFE (−2), B=3, `start` pulse → `busy`=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu → HI=0x00000002, LO=0xFFFFFFFA.
- Signed divide: div A=−7 (0xFFFFFFF9), B=2 → `busy` 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Repeat as divu A=7, B=2 → LO=3, HI=1.
- Divide edge cases:
  - div by zero with HI=0x11, LO=0x22 preloaded → `busy` 10 cycles; HI/LO still 0x11/0x22.
  - 0x80000000 / −1 → LO=0x80000000, HI=0.
- Busy interlock:
  - During mult, pulse `start`+div and assert mthi A=0x55 → both ignored; final HI/LO match the mult result.
  - Back-to-back `start` in cycle N+1 → accepted.
- Flush and move:
  - mtlo A=0xABCD with `req`=1 → LO unchanged.
  - With `req`=0 → LO=0xABCD next cycle; MDOP=8 → `MDOUT`=0xABCD combinationally.
- Async reset mid-divide: drop `rst_n` at cycle 4 of a div → `busy`, HI, LO go to 0 immediately, without waiting for a clock edge. After release, a new mult completes normally.
